// File: rtl/blink_period_meter.sv
// Measures the CE-qualified half-period of an async toggling line; flags lock and edge timeout.
// Latency: in_sig change sampled at edge k reports on edge k+2; no backpressure, valid is a bare strobe.
module blink_period_meter #(
    parameter int CNT_W          = 23,
    parameter int EXPECT         = 3_000_000,
    parameter int TOL            = 1000,
    parameter int TIMEOUT_CYCLES = 6_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             in_sig,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_chk
        $error("CNT_W too narrow to hold TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [63:0]      LO_B    = (EXPECT > TOL) ? 64'(EXPECT - TOL) : 64'd0;
    localparam logic [63:0]      HI_B    = 64'(EXPECT) + 64'(TOL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_d;
    logic             valid_d, locked_d, timeout_d;
    logic             last_ok_q, last_ok_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             edge_det;
    logic             in_tol;

    // prev only follows sync2 on CE cycles, so an edge seen while CE=0 stays pending
    assign edge_det = CE & (sync2_q ^ prev_q);
    assign in_tol   = (64'(count_q) >= LO_B) && (64'(count_q) <= HI_B);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period;
        valid_d   = 1'b0;
        locked_d  = locked;
        timeout_d = timeout;
        last_ok_d = last_ok_q;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (edge_det) begin
                    state_d = S_MEASURE;
                    count_d = CNT_W'(1);
                end
            end
            S_MEASURE: begin
                if (edge_det) begin
                    period_d  = count_q;
                    valid_d   = 1'b1;
                    count_d   = CNT_W'(1);
                    if (!in_tol) begin
                        locked_d = 1'b0;
                    end else if (last_ok_q) begin
                        locked_d = 1'b1;
                    end
                    last_ok_d = in_tol;
                end else if (CE) begin
                    if (count_q == TMO_CNT) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        last_ok_d = 1'b0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_TIMEOUT: begin
                // restart edge re-arms only; the gap before it is not a valid period
                if (edge_det) begin
                    state_d   = S_MEASURE;
                    count_d   = CNT_W'(1);
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            period    <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            last_ok_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period    <= period_d;
            valid     <= valid_d;
            locked    <= locked_d;
            timeout   <= timeout_d;
            last_ok_q <= last_ok_d;
            sync1_q   <= in_sig;
            sync2_q   <= sync1_q;
            if (CE) begin
                prev_q <= sync2_q;
            end
        end
    end

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with EXPECT=30, TOL=2, TIMEOUT_CYCLES=60, CNT_W=8.
module tb_blink_period_meter;

    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CE = 1'b0;
    logic             in_sig = 1'b0;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             locked;
    logic             timeout;

    int n_chk = 0;
    int n_err = 0;

    blink_period_meter #(
        .CNT_W(CNT_W),
        .EXPECT(30),
        .TOL(2),
        .TIMEOUT_CYCLES(60)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CE(CE),
        .in_sig(in_sig),
        .period(period),
        .valid(valid),
        .locked(locked),
        .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // Toggle in_sig at the current falling edge, then run n cycles. The edge's report is
    // expected at offset off; exactly exp_v valid strobes may appear in the window.
    // alt=1 drives CE 0,1,0,1,... starting with 0 at the toggle.
    task automatic win(input int n, input bit alt, input int off, input bit exp_v,
                       input int exp_p, input bit exp_l, input string tag);
        int nv;
        nv = 0;
        in_sig = ~in_sig;
        CE = alt ? 1'b0 : 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (valid) nv++;
            if (i == off) begin
                if (exp_v) begin
                    check({tag, "_valid"}, 32'(valid), 1);
                    check({tag, "_period"}, 32'(period), 32'(exp_p));
                end
                check({tag, "_locked"}, 32'(locked), 32'(exp_l));
                check({tag, "_timeout"}, 32'(timeout), 0);
            end
            if (i < n) CE = alt ? 1'((i % 2)) : 1'b1;
        end
        check({tag, "_nvalid"}, nv, 32'(exp_v));
    endtask

    initial begin
        // 1: reset held while in_sig toggles
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_clear("t1_rst");
            in_sig = ~in_sig;
        end
        in_sig = 1'b0;
        RST = 1'b0;
        CE = 1'b1;
        repeat (4) @(negedge CLK);
        check_clear("t1_idle");

        // 2: 30-cycle half-period, first edge arms, lock from third edge
        win(30, 0, 3, 0, 0, 0, "t2_arm");
        win(30, 0, 3, 1, 30, 0, "t2_e2");
        win(30, 0, 3, 1, 30, 1, "t2_e3");
        win(40, 0, 3, 1, 30, 1, "t2_e4");

        // 3: off-nominal periods and inclusive tolerance bounds
        win(31, 0, 3, 1, 40, 0, "t3_p40");
        win(29, 0, 3, 1, 31, 0, "t3_p31");
        win(32, 0, 3, 1, 29, 1, "t3_p29");
        win(28, 0, 3, 1, 32, 1, "t3_p32");
        win(27, 0, 3, 1, 28, 1, "t3_p28");
        win(33, 0, 3, 1, 27, 0, "t3_p27");
        win(30, 0, 3, 1, 33, 0, "t3_p33");
        win(30, 0, 3, 1, 30, 0, "t3_p30");

        // 4: edges stop after lock
        win(62, 0, 3, 1, 30, 1, "t4_last");
        check("t4_pre_timeout", 32'(timeout), 0);
        @(negedge CLK);
        check("t4_timeout", 32'(timeout), 1);
        check("t4_locked", 32'(locked), 0);
        repeat (5) @(negedge CLK);
        check("t4_hold_timeout", 32'(timeout), 1);
        check("t4_hold_valid", 32'(valid), 0);
        win(30, 0, 3, 0, 0, 0, "t4_restart");
        win(30, 0, 3, 1, 30, 0, "t4_meas");

        // 6: reset while count=15
        win(17, 0, 3, 1, 30, 1, "t6_pre");
        RST = 1'b1;
        in_sig = 1'b0;
        @(negedge CLK);
        check_clear("t6_rst");
        RST = 1'b0;
        win(30, 0, 3, 0, 0, 0, "t6_arm");
        win(30, 0, 3, 1, 30, 0, "t6_meas");

        // 5: CE alternating, 60-clock half-period; edges land on CE=0 and wait one cycle
        RST = 1'b1;
        in_sig = 1'b0;
        @(negedge CLK);
        check_clear("t5_rst");
        RST = 1'b0;
        win(60, 1, 4, 0, 0, 0, "t5_arm");
        win(60, 1, 4, 1, 30, 0, "t5_e2");
        win(60, 1, 4, 1, 30, 1, "t5_e3");
        CE = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
